tt_sel_ctrl: RTL

TT_SEL_CTRL -- requirements
Module: tt_sel_ctrl

---
 rtl/tt_sel_ctrl_pkg.sv | 40 ++++
 rtl/tt_sel_sync.sv | 31 +++
 rtl/tt_sel_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/tt_sel_ctrl_pkg.sv
// tt_sel_ctrl_pkg -- shared definitions for the tiny-tapeout spine select
// controller: select width, address field positions, parameter defaults and
// the enable FSM state type.
package tt_sel_ctrl_pkg;

  // Spine select bus width and default build parameters
  localparam int SEL_W           = 10;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int GUARD_CYC_DEF   = 4;

  // Row address lives in spine_sel[9:6] and spine_sel[4]
  localparam int ROW_HI_MSB = 9;
  localparam int ROW_HI_LSB = 6;
  localparam int ROW_LO_BIT = 4;
  // Column / top-bottom address lives in spine_sel[5] and spine_sel[3:0]
  localparam int COL_HI_BIT = 5;
  localparam int COL_LO_MSB = 3;
  localparam int COL_LO_LSB = 0;

  // Width of the break-before-make guard counter (GUARD_CYC up to 15)
  localparam int GCNT_W = 4;

  // Spine enable FSM states
  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_GUARD = 2'd1,
    ST_ON    = 2'd2
  } state_t;

  // Row address of a select word
  function automatic logic [4:0] row_addr(input logic [SEL_W-1:0] sel);
    return {sel[ROW_HI_MSB:ROW_HI_LSB], sel[ROW_LO_BIT]};
  endfunction

  // Column / top-bottom address of a select word
  function automatic logic [4:0] col_addr(input logic [SEL_W-1:0] sel);
    return {sel[COL_HI_BIT], sel[COL_LO_MSB:COL_LO_LSB]};
  endfunction

endpackage

// File: rtl/tt_sel_sync.sv
// tt_sel_sync -- STAGES-deep flop synchronizer for one asynchronous pin,
// cleared asynchronously by an active-high clear.
module tt_sel_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  // Shift the pin value one stage further down the chain each cycle
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  // Synchronizer flops, cleared asynchronously
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/tt_sel_ctrl.sv
// tt_sel_ctrl -- spine select counter and break-before-make spine enable.
// Three asynchronous pins (sel_rst, sel_inc, ena_req) are synchronized; a
// 10-bit counter drives spine_sel directly. With macro TT_SEL_GUARD_EN
// defined, spine_ena drops on every select change and only returns after a
// GUARD_CYC guard interval; without it spine_ena simply follows the request.
module tt_sel_ctrl
  import tt_sel_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int GUARD_CYC   = GUARD_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel_rst,
  input  logic             sel_inc,
  input  logic             ena_req,
  output logic [SEL_W-1:0] spine_sel,
  output logic             spine_ena,
  output logic             guard
);

  logic s_rst;
  logic s_inc;
  logic s_ena;

  tt_sel_sync #(.STAGES(SYNC_STAGES)) u_sync_rst (
    .clk (clk), .clr (rst), .d (sel_rst), .q (s_rst)
  );
  tt_sel_sync #(.STAGES(SYNC_STAGES)) u_sync_inc (
    .clk (clk), .clr (rst), .d (sel_inc), .q (s_inc)
  );
  tt_sel_sync #(.STAGES(SYNC_STAGES)) u_sync_ena (
    .clk (clk), .clr (rst), .d (ena_req), .q (s_ena)
  );

  // ---------------------------------------------------------------------
  // Increment edge detect. Until the synchronizer has been refilled after
  // reset the registered copy is held high, so a pin that was already high
  // at reset release never looks like a fresh rising edge.
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] flush_q;
  logic [SYNC_STAGES-1:0] flush_d;
  logic                   inc_prev_q;
  logic                   inc_prev_d;
  logic                   inc_pulse;

  // Track synchronizer refill and the previous synchronized sel_inc level
  always_comb begin
    flush_d    = {flush_q[SYNC_STAGES-2:0], 1'b1};
    inc_prev_d = flush_q[SYNC_STAGES-1] ? s_inc : 1'b1;
    inc_pulse  = s_inc & ~inc_prev_q;
  end

  // Edge-detect and refill-tracking flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q    <= '0;
      inc_prev_q <= 1'b0;
    end else begin
      flush_q    <= flush_d;
      inc_prev_q <= inc_prev_d;
    end
  end

  // ---------------------------------------------------------------------
  // Select counter: clear wins over increment, wraps 1023 -> 0.
  // ---------------------------------------------------------------------
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_d;
  logic             sel_chg;

  // Next select value and select-change flag
  always_comb begin
    if (s_rst) begin
      sel_d = '0;
    end else if (inc_pulse) begin
      sel_d = sel_q + SEL_W'(1);
    end else begin
      sel_d = sel_q;
    end
    sel_chg = (sel_d != sel_q);
  end

  // Select counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign spine_sel = sel_q;

  // ---------------------------------------------------------------------
  // Spine enable
  // ---------------------------------------------------------------------
  logic ena_q;
  logic ena_d;

`ifdef TT_SEL_GUARD_EN
  localparam logic [GCNT_W-1:0] GCNT_END = GCNT_W'(GUARD_CYC);

  state_t            state_q;
  state_t            state_d;
  logic [GCNT_W-1:0] gcnt_q;
  logic [GCNT_W-1:0] gcnt_d;
  logic              guard_q;
  logic              guard_d;

  // Enable FSM next state; outputs are decoded from the next state so that
  // spine_ena falls on the very edge that loads a new select value.
  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      ST_OFF: begin
        if (s_ena && !s_rst) begin
          state_d = ST_GUARD;
          gcnt_d  = '0;
        end
      end
      ST_GUARD: begin
        if (s_rst) begin
          state_d = ST_OFF;
          gcnt_d  = '0;
        end else if (sel_chg) begin
          gcnt_d  = '0;
        end else if (gcnt_q == GCNT_END) begin
          state_d = s_ena ? ST_ON : ST_OFF;
          gcnt_d  = '0;
        end else begin
          gcnt_d  = gcnt_q + GCNT_W'(1);
        end
      end
      ST_ON: begin
        if (s_rst || !s_ena) begin
          state_d = ST_OFF;
        end else if (sel_chg) begin
          state_d = ST_GUARD;
          gcnt_d  = '0;
        end
      end
      default: begin
        state_d = ST_OFF;
        gcnt_d  = '0;
      end
    endcase
    ena_d   = (state_d == ST_ON);
    guard_d = (state_d == ST_GUARD);
  end

  // FSM state, guard counter and guard output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_OFF;
      gcnt_q  <= '0;
      guard_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
      guard_q <= guard_d;
    end
  end

  assign guard = guard_q;
`else
  // Enable simply follows the synchronized request, blocked by sel_rst
  always_comb begin
    ena_d = s_ena & ~s_rst;
  end

  assign guard = 1'b0;
`endif

  // Spine enable output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ena_q <= 1'b0;
    end else begin
      ena_q <= ena_d;
    end
  end

  assign spine_ena = ena_q;

endmodule
